// File: rtl/alu_pkg.sv
// Shared definitions for the sequential calculator ALU: op codes, FSM states, width helpers.
// The CONV state exists only when ALU_BCD_OUT_EN is defined.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MUL,
        S_DIV,
`ifdef ALU_BCD_OUT_EN
        S_CONV,
`endif
        S_FIN
    } alu_state_e;

    function automatic int unsigned calc_max_val(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

    function automatic int unsigned calc_bits(input int unsigned digits);
        return $clog2(calc_max_val(digits) + 1);
    endfunction

endpackage

// File: rtl/bin_a_bcd_seq.sv
// Sequential double-dabble: binary to packed BCD, one shift per cycle, start/done handshake.
module bin_a_bcd_seq
    import alu_pkg::*;
#(
    parameter  int unsigned DIGITS = 4,
    localparam int unsigned BITS   = calc_bits(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [BITS-1:0]       bin_i,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BITS + 1);

    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj_d;
    logic [BITS-1:0]  bin_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic             done_q;

    always_comb begin
        adj_d = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // The load cycle already performs the first shift (the empty BCD needs no
    // adjust), so a full conversion spans exactly BITS clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                bcd_q    <= {{(BCD_W-1){1'b0}}, bin_i[BITS-1]};
                bin_q    <= bin_i << 1;
                cnt_q    <= CNT_W'(BITS - 1);
                active_q <= 1'b1;
            end else if (active_q) begin
                bcd_q <= {adj_d[BCD_W-2:0], bin_q[BITS-1]};
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    active_q <= 1'b0;
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/alu_secuencial.sv
// Multi-cycle saturating decimal-range ALU (add/sub/shift-add mul/restoring div).
// Define ALU_BCD_OUT_EN to add a sequential BCD conversion stage driving bcd.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter  int unsigned DIGITS  = 4,
    localparam int unsigned BITS    = calc_bits(DIGITS),
    localparam int unsigned MAX_VAL = calc_max_val(DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [BITS-1:0]       a,
    input  logic [BITS-1:0]       b,
    output logic                  busy,
    output logic                  done,
    output logic [BITS-1:0]       result,
    output logic                  negative,
    output logic                  overflow,
    output logic                  div_zero,
    output logic [BITS-1:0]       rem,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam logic [BITS-1:0]  MAX_B     = BITS'(MAX_VAL);
    localparam int unsigned      CNT_W     = $clog2(BITS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BITS - 1);

    alu_state_e         state_q;
    logic [1:0]         op_q;
    logic [BITS-1:0]    a_q;
    logic [BITS-1:0]    b_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [2*BITS-1:0]  mcand_q;
    logic [2*BITS-1:0]  acc_q;
    logic [2*BITS-1:0]  acc_d;
    logic [BITS-1:0]    mplier_q;

    logic [BITS-1:0]    quo_q;
    logic [BITS-1:0]    quo_d;
    logic [BITS-1:0]    part_q;
    logic [BITS-1:0]    part_d;
    logic [BITS:0]      trial_d;
    logic [BITS:0]      sum_d;

    logic               fin_go_d;
    logic [BITS-1:0]    fin_res_d;
    logic [BITS-1:0]    fin_rem_d;
    logic               fin_neg_d;
    logic               fin_ovf_d;
    logic               fin_dz_d;

    logic               busy_q;
    logic               done_q;
    logic [BITS-1:0]    result_q;
    logic [BITS-1:0]    rem_q;
    logic               negative_q;
    logic               overflow_q;
    logic               div_zero_q;

`ifdef ALU_BCD_OUT_EN
    logic               conv_done;
    logic [4*DIGITS-1:0] conv_bcd;
    logic [4*DIGITS-1:0] bcd_q;
    logic [BITS-1:0]    pend_res_q;
    logic [BITS-1:0]    pend_rem_q;
    logic               pend_neg_q;
    logic               pend_ovf_q;
    logic               pend_dz_q;
`endif

    always_comb begin
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
        trial_d = {part_q, quo_q[BITS-1]};
        if (trial_d >= {1'b0, b_q}) begin
            part_d = BITS'(trial_d - {1'b0, b_q});
            quo_d  = {quo_q[BITS-2:0], 1'b1};
        end else begin
            part_d = trial_d[BITS-1:0];
            quo_d  = {quo_q[BITS-2:0], 1'b0};
        end

        fin_go_d  = 1'b0;
        fin_res_d = '0;
        fin_rem_d = '0;
        fin_neg_d = 1'b0;
        fin_ovf_d = 1'b0;
        fin_dz_d  = 1'b0;
        case (state_q)
            S_CHECK: begin
                if (a_q > MAX_B || b_q > MAX_B) begin
                    fin_go_d  = 1'b1;
                    fin_ovf_d = 1'b1;
                    fin_res_d = MAX_B;
                end else begin
                    case (op_q)
                        OP_ADD: begin
                            fin_go_d = 1'b1;
                            if (sum_d > {1'b0, MAX_B}) begin
                                fin_ovf_d = 1'b1;
                                fin_res_d = MAX_B;
                            end else begin
                                fin_res_d = sum_d[BITS-1:0];
                            end
                        end
                        OP_SUB: begin
                            fin_go_d  = 1'b1;
                            fin_neg_d = (a_q < b_q);
                            fin_res_d = (a_q < b_q) ? (b_q - a_q) : (a_q - b_q);
                        end
                        OP_DIV: begin
                            if (b_q == '0) begin
                                fin_go_d  = 1'b1;
                                fin_dz_d  = 1'b1;
                                fin_res_d = MAX_B;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == LAST_STEP) begin
                    fin_go_d = 1'b1;
                    if (acc_d > {{BITS{1'b0}}, MAX_B}) begin
                        fin_ovf_d = 1'b1;
                        fin_res_d = MAX_B;
                    end else begin
                        fin_res_d = acc_d[BITS-1:0];
                    end
                end
            end
            S_DIV: begin
                if (cnt_q == LAST_STEP) begin
                    fin_go_d  = 1'b1;
                    fin_res_d = quo_d;
                    fin_rem_d = part_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            mplier_q   <= '0;
            quo_q      <= '0;
            part_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            rem_q      <= '0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef ALU_BCD_OUT_EN
            bcd_q      <= '0;
            pend_res_q <= '0;
            pend_rem_q <= '0;
            pend_neg_q <= 1'b0;
            pend_ovf_q <= 1'b0;
            pend_dz_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cnt_q    <= '0;
                    mcand_q  <= {{BITS{1'b0}}, a_q};
                    mplier_q <= b_q;
                    acc_q    <= '0;
                    quo_q    <= a_q;
                    part_q   <= '0;
                    state_q  <= (op_q == OP_MUL) ? S_MUL : S_DIV;
                end
                S_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                end
                S_DIV: begin
                    quo_q  <= quo_d;
                    part_q <= part_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
`ifdef ALU_BCD_OUT_EN
                S_CONV: begin
                    if (conv_done) begin
                        result_q   <= pend_res_q;
                        rem_q      <= pend_rem_q;
                        negative_q <= pend_neg_q;
                        overflow_q <= pend_ovf_q;
                        div_zero_q <= pend_dz_q;
                        bcd_q      <= conv_bcd;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_FIN;
                    end
                end
`endif
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            // A finishing compute step overrides whatever next state the case chose.
            if (fin_go_d) begin
`ifdef ALU_BCD_OUT_EN
                pend_res_q <= fin_res_d;
                pend_rem_q <= fin_rem_d;
                pend_neg_q <= fin_neg_d;
                pend_ovf_q <= fin_ovf_d;
                pend_dz_q  <= fin_dz_d;
                state_q    <= S_CONV;
`else
                result_q   <= fin_res_d;
                rem_q      <= fin_rem_d;
                negative_q <= fin_neg_d;
                overflow_q <= fin_ovf_d;
                div_zero_q <= fin_dz_d;
                done_q     <= 1'b1;
                busy_q     <= 1'b0;
                state_q    <= S_FIN;
`endif
            end
        end
    end

`ifdef ALU_BCD_OUT_EN
    bin_a_bcd_seq #(.DIGITS(DIGITS)) u_bcd (
        .clk     (clk),
        .rst     (rst),
        .start_i (fin_go_d),
        .bin_i   (fin_res_d),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );
    assign bcd = bcd_q;
`else
    assign bcd = '0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign rem      = rem_q;
    assign negative = negative_q;
    assign overflow = overflow_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Scoreboard bench for alu_secuencial: directed and random ops against an arithmetic reference model.
module tb_alu_secuencial;

    localparam int DIGITS = 4;
    localparam int MAXV   = 10**DIGITS - 1;
    localparam int BITS   = $clog2(10**DIGITS);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [1:0]          op = '0;
    logic [BITS-1:0]     a = '0;
    logic [BITS-1:0]     b = '0;
    logic                busy, done, negative, overflow, div_zero;
    logic [BITS-1:0]     result, rem;
    logic [4*DIGITS-1:0] bcd;

    typedef struct {
        int res;
        int rm;
        bit neg;
        bit ovf;
        bit dz;
        int bcdv;
        int lat;
        int t0;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    longint last_pub = 0;

    alu_secuencial #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .negative (negative),
        .overflow (overflow),
        .div_zero (div_zero),
        .rem      (rem),
        .bcd      (bcd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint pack(input longint r, input longint m, input longint d,
                                    input longint n, input longint o, input longint z);
        return (r << 33) | (m << 19) | (d << 3) | (n << 2) | (o << 1) | z;
    endfunction

    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int   v;
        e = '{res: 0, rm: 0, neg: 0, ovf: 0, dz: 0, bcdv: 0, lat: 2, t0: 0};
        if (x > MAXV || y > MAXV) begin
            e.ovf = 1; e.res = MAXV;
        end else if (o == 0) begin
            if (x + y > MAXV) begin e.ovf = 1; e.res = MAXV; end
            else e.res = x + y;
        end else if (o == 1) begin
            e.neg = (x < y);
            e.res = (x < y) ? y - x : x - y;
        end else if (o == 2) begin
            e.lat = BITS + 2;
            if (x * y > MAXV) begin e.ovf = 1; e.res = MAXV; end
            else e.res = x * y;
        end else if (y == 0) begin
            e.dz = 1; e.res = MAXV;
        end else begin
            e.lat = BITS + 2;
            e.res = x / y;
            e.rm  = x % y;
        end
`ifdef ALU_BCD_OUT_EN
        v = e.res;
        for (int i = 0; i < DIGITS; i++) begin
            e.bcdv = e.bcdv + ((v % 10) << (4 * i));
            v = v / 10;
        end
        e.lat = e.lat + BITS;
`else
        v = 0;
        e.bcdv = v;
`endif
        return e;
    endfunction

    // Monitor: pops an expectation on every done pulse; otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst) begin
            last_pub = 0;
        end else if (done) begin
            check("pending_txn", longint'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("result",   result,   mon_e.res);
                check("rem",      rem,      mon_e.rm);
                check("negative", negative, mon_e.neg);
                check("overflow", overflow, mon_e.ovf);
                check("div_zero", div_zero, mon_e.dz);
                check("bcd",      bcd,      mon_e.bcdv);
                check("latency",  cyc - mon_e.t0, mon_e.lat);
                check("busy_at_done", busy, 0);
                last_pub = pack(mon_e.res, mon_e.rm, mon_e.bcdv, mon_e.neg, mon_e.ovf, mon_e.dz);
            end
        end else begin
            check("hold", pack(result, rem, bcd, negative, overflow, div_zero), last_pub);
        end
    end

    task automatic launch(input int o, input int x, input int y);
        exp_t e;
        @(negedge clk);
        e = model(o, x, y);
        e.t0 = cyc;
        sb.push_back(e);
        start = 1'b1;
        op    = 2'(o);
        a     = BITS'(x);
        b     = BITS'(y);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            got = done;
        end
        check("done_seen", got, 1);
        if (!got) sb.delete();
    endtask

    task automatic run(input int o, input int x, input int y);
        launch(o, x, y);
        wait_done();
    endtask

    int d_op[] = '{0,    0,    0,     1,   1,   2,   2,   3,    3,    0,    3,     2, 3,  1};
    int d_a[]  = '{4000, 5000, 1234,  12,  500, 99,  100, 9999, 9999, 10000, 12000, 0, 5,  777};
    int d_b[]  = '{5999, 5000, 0,     500, 12,  101, 100, 7,    0,    1,     0,     9999, 9, 777};

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outputs", pack(result, rem, bcd, negative, overflow, div_zero), 0);
        check("rst_busy_done", {busy, done}, 0);
        #2 rst = 1'b0;

        foreach (d_op[i]) run(d_op[i], d_a[i], d_b[i]);

        for (int i = 0; i < 40; i++) begin
            int o, x, y, sel;
            o   = $urandom_range(0, 3);
            sel = $urandom_range(0, 9);
            x   = $urandom_range(0, MAXV);
            y   = $urandom_range(0, MAXV);
            if (sel == 0) x = $urandom_range(MAXV + 1, (1 << BITS) - 1);
            if (sel == 1) y = 0;
            if (o == 2 && sel > 5) begin
                x = $urandom_range(0, 150);
                y = $urandom_range(0, 150);
            end
            run(o, x, y);
        end

        // A start while busy must be dropped, not queued.
        launch(2, 37, 41);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 14'd1; b = 14'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (6) @(negedge clk);

        // Asynchronous reset in the middle of a multiply.
        launch(2, 99, 101);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_outputs", pack(result, rem, bcd, negative, overflow, div_zero), 0);
        check("rst_mid_busy_done", {busy, done}, 0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        run(0, 1, 1);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
